vga_rom_pic_jump_top: RTL and testbench



---
 rtl/vga_rom_pic_jump_top_if.sv | 10 +
 rtl/vga_rom_pic_jump_top.sv | 257 +++++++++++++++++++++++++
 tb/tb_vga_rom_pic_jump_top.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/vga_rom_pic_jump_top_if.sv
// VGA connector bundle: sync pulses and RGB565 pixel data.
// The timing generator drives it as master; the board/monitor side is the slave.
interface vga_rom_pic_jump_top_if;
  logic        hsync;
  logic        vsync;
  logic [15:0] vga_rgb;

  modport master (output hsync, vsync, vga_rgb);
  modport slave  (input  hsync, vsync, vga_rgb);
endinterface

// File: rtl/vga_rom_pic_jump_top.sv
// VGA timing plus a ROM picture bouncing diagonally one pixel per frame; outputs are combinational from registers.
// The ROM is a synchronous one-clock-latency read returning {2'b10, addr}.

module vga_ctrl #(
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 40,
  parameter int H_LEFT   = 8,
  parameter int H_VALID  = 640,
  parameter int H_RIGHT  = 8,
  parameter int H_FRONT  = 8,
  parameter int H_TOTAL  = 800,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 25,
  parameter int V_TOP    = 8,
  parameter int V_VALID  = 480,
  parameter int V_BOTTOM = 8,
  parameter int V_FRONT  = 2,
  parameter int V_TOTAL  = 525
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [15:0] pix_data,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic        hsync,
  output logic        vsync,
  output logic [15:0] vga_rgb
);
  localparam int H_SUM = H_SYNC + H_BACK + H_LEFT + H_VALID + H_RIGHT + H_FRONT;
  localparam int V_SUM = V_SYNC + V_BACK + V_TOP + V_VALID + V_BOTTOM + V_FRONT;
  localparam int HS0   = H_SYNC + H_BACK + H_LEFT;
  localparam int VS0   = V_SYNC + V_BACK + V_TOP;

  localparam logic [9:0] HT_M1 = 10'(H_TOTAL - 1);
  localparam logic [9:0] VT_M1 = 10'(V_TOTAL - 1);
  localparam logic [9:0] HSYNC = 10'(H_SYNC);
  localparam logic [9:0] VSYNC = 10'(V_SYNC);
  localparam logic [9:0] HA_LO = 10'(HS0);
  localparam logic [9:0] HA_HI = 10'(HS0 + H_VALID - 1);
  localparam logic [9:0] HR_LO = 10'(HS0 - 1);
  localparam logic [9:0] HR_HI = 10'(HS0 + H_VALID - 2);
  localparam logic [9:0] VA_LO = 10'(VS0);
  localparam logic [9:0] VA_HI = 10'(VS0 + V_VALID - 1);

  if (H_SUM != H_TOTAL) begin : g_h_chk
    $error("H_TOTAL does not equal the sum of the horizontal fields");
  end
  if (V_SUM != V_TOTAL) begin : g_v_chk
    $error("V_TOTAL does not equal the sum of the vertical fields");
  end

  logic [9:0] cnt_h;
  logic [9:0] cnt_v;
  logic       v_act;
  logic       rgb_valid;
  logic       pix_req;

  always_ff @(posedge sys_clk or posedge sys_rst_n) begin
    if (sys_rst_n) begin
      cnt_h <= '0;
      cnt_v <= '0;
    end else begin
      if (cnt_h == HT_M1) begin
        cnt_h <= '0;
        cnt_v <= (cnt_v == VT_M1) ? 10'd0 : cnt_v + 10'd1;
      end else begin
        cnt_h <= cnt_h + 10'd1;
      end
    end
  end

  assign hsync     = (cnt_h < HSYNC);
  assign vsync     = (cnt_v < VSYNC);
  assign v_act     = (cnt_v >= VA_LO) && (cnt_v <= VA_HI);
  assign rgb_valid = v_act && (cnt_h >= HA_LO) && (cnt_h <= HA_HI);
  // One clock ahead of rgb_valid so the ROM read lands on the visible cycle.
  assign pix_req   = v_act && (cnt_h >= HR_LO) && (cnt_h <= HR_HI);
  assign pix_x     = pix_req ? (cnt_h - HR_LO) : 10'h3FF;
  assign pix_y     = pix_req ? (cnt_v - VA_LO) : 10'h3FF;
  assign vga_rgb   = rgb_valid ? pix_data : 16'h0000;
endmodule

module vga_pic #(
  parameter int H_VALID  = 640,
  parameter int V_VALID  = 480,
  parameter int H_PIC    = 100,
  parameter int V_PIC    = 100,
  parameter int PIC_SIZE = 10000
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [9:0]  pix_x,
  input  logic [9:0]  pix_y,
  output logic [15:0] pix_data
);
  localparam logic [9:0]  X_MAX     = 10'(H_VALID - H_PIC);
  localparam logic [9:0]  Y_MAX     = 10'(V_VALID - V_PIC);
  localparam logic [9:0]  X_END     = 10'(H_VALID - 1);
  localparam logic [9:0]  Y_END     = 10'(V_VALID - 1);
  localparam logic [9:0]  HP_M1     = 10'(H_PIC - 1);
  localparam logic [9:0]  VP_M1     = 10'(V_PIC - 1);
  localparam logic [13:0] ADDR_LAST = 14'(PIC_SIZE - 1);

  logic [9:0]  x_pos;
  logic [9:0]  y_pos;
  logic        dx;
  logic        dy;
  logic [13:0] rom_addr;
  logic        rd_en_d;
  logic [15:0] rom_q;
  logic        in_pic;
  logic        frame_end;
  logic [9:0]  nx;
  logic [9:0]  ny;

  assign in_pic = (pix_x >= x_pos) && (pix_x <= x_pos + HP_M1) &&
                  (pix_y >= y_pos) && (pix_y <= y_pos + VP_M1);
  assign frame_end = (pix_x == X_END) && (pix_y == Y_END);

  always_comb begin
    nx = dx ? x_pos - 10'd1 : x_pos + 10'd1;
    ny = dy ? y_pos - 10'd1 : y_pos + 10'd1;
  end

  always_ff @(posedge sys_clk or posedge sys_rst_n) begin
    if (sys_rst_n) begin
      x_pos    <= '0;
      y_pos    <= '0;
      dx       <= 1'b0;
      dy       <= 1'b0;
      rom_addr <= '0;
      rd_en_d  <= 1'b0;
    end else begin
      rd_en_d <= in_pic;
      if (frame_end)
        rom_addr <= '0;
      else if (in_pic)
        rom_addr <= (rom_addr == ADDR_LAST) ? 14'd0 : rom_addr + 14'd1;
      // Direction flips on the frame that lands on an edge, so the next frame moves away.
      if (frame_end) begin
        x_pos <= nx;
        y_pos <= ny;
        if (nx == X_MAX)      dx <= 1'b1;
        else if (nx == 10'd0) dx <= 1'b0;
        if (ny == Y_MAX)      dy <= 1'b1;
        else if (ny == 10'd0) dy <= 1'b0;
      end
    end
  end

  always_ff @(posedge sys_clk) rom_q <= {2'b10, rom_addr};

  assign pix_data = rd_en_d ? rom_q : 16'h0000;
endmodule

module vga_rom_pic_jump #(
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 40,
  parameter int H_LEFT   = 8,
  parameter int H_VALID  = 640,
  parameter int H_RIGHT  = 8,
  parameter int H_FRONT  = 8,
  parameter int H_TOTAL  = 800,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 25,
  parameter int V_TOP    = 8,
  parameter int V_VALID  = 480,
  parameter int V_BOTTOM = 8,
  parameter int V_FRONT  = 2,
  parameter int V_TOTAL  = 525,
  parameter int H_PIC    = 100,
  parameter int V_PIC    = 100,
  parameter int PIC_SIZE = 10000
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  output logic        hsync,
  output logic        vsync,
  output logic [15:0] vga_rgb
);
  logic [9:0]  pix_x;
  logic [9:0]  pix_y;
  logic [15:0] pix_data;

  vga_ctrl #(
    .H_SYNC(H_SYNC), .H_BACK(H_BACK), .H_LEFT(H_LEFT), .H_VALID(H_VALID),
    .H_RIGHT(H_RIGHT), .H_FRONT(H_FRONT), .H_TOTAL(H_TOTAL),
    .V_SYNC(V_SYNC), .V_BACK(V_BACK), .V_TOP(V_TOP), .V_VALID(V_VALID),
    .V_BOTTOM(V_BOTTOM), .V_FRONT(V_FRONT), .V_TOTAL(V_TOTAL)
  ) vga_ctrl_inst (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .pix_data (pix_data),
    .pix_x    (pix_x),
    .pix_y    (pix_y),
    .hsync    (hsync),
    .vsync    (vsync),
    .vga_rgb  (vga_rgb)
  );

  vga_pic #(
    .H_VALID(H_VALID), .V_VALID(V_VALID),
    .H_PIC(H_PIC), .V_PIC(V_PIC), .PIC_SIZE(PIC_SIZE)
  ) vga_pic_inst (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .pix_x    (pix_x),
    .pix_y    (pix_y),
    .pix_data (pix_data)
  );
endmodule

module vga_rom_pic_jump_top #(
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 40,
  parameter int H_LEFT   = 8,
  parameter int H_VALID  = 640,
  parameter int H_RIGHT  = 8,
  parameter int H_FRONT  = 8,
  parameter int H_TOTAL  = 800,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 25,
  parameter int V_TOP    = 8,
  parameter int V_VALID  = 480,
  parameter int V_BOTTOM = 8,
  parameter int V_FRONT  = 2,
  parameter int V_TOTAL  = 525,
  parameter int H_PIC    = 100,
  parameter int V_PIC    = 100,
  parameter int PIC_SIZE = 10000
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst_n,
  vga_rom_pic_jump_top_if.master vga
);
  logic        hsync;
  logic        vsync;
  logic [15:0] vga_rgb;

  vga_rom_pic_jump #(
    .H_SYNC(H_SYNC), .H_BACK(H_BACK), .H_LEFT(H_LEFT), .H_VALID(H_VALID),
    .H_RIGHT(H_RIGHT), .H_FRONT(H_FRONT), .H_TOTAL(H_TOTAL),
    .V_SYNC(V_SYNC), .V_BACK(V_BACK), .V_TOP(V_TOP), .V_VALID(V_VALID),
    .V_BOTTOM(V_BOTTOM), .V_FRONT(V_FRONT), .V_TOTAL(V_TOTAL),
    .H_PIC(H_PIC), .V_PIC(V_PIC), .PIC_SIZE(PIC_SIZE)
  ) u_vga_rom_pic_jump (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .hsync    (hsync),
    .vsync    (vsync),
    .vga_rgb  (vga_rgb)
  );

  assign vga.hsync   = hsync;
  assign vga.vsync   = vsync;
  assign vga.vga_rgb = vga_rgb;
endmodule

// File: tb/tb_vga_rom_pic_jump_top.sv
// Directed bench: dut1 uses the reduced 70x60 timing, dut2 a tiny 17x13 timing to reach the bounce edges quickly.
module tb_vga_rom_pic_jump_top;
  localparam int FT1 = 4200;
  localparam int HT1 = 70;
  localparam int FT2 = 221;
  localparam int HT2 = 17;

  logic sys_clk = 1'b0;
  logic rst1 = 1'b1;
  logic rst2 = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  vga_rom_pic_jump_top_if vif1 ();
  vga_rom_pic_jump_top_if vif2 ();

  vga_rom_pic_jump_top #(
    .H_SYNC(2), .H_BACK(2), .H_LEFT(2), .H_VALID(60), .H_RIGHT(2), .H_FRONT(2), .H_TOTAL(70),
    .V_SYNC(2), .V_BACK(2), .V_TOP(2), .V_VALID(50), .V_BOTTOM(2), .V_FRONT(2), .V_TOTAL(60),
    .H_PIC(10), .V_PIC(10), .PIC_SIZE(100)
  ) dut1 (
    .sys_clk  (sys_clk),
    .sys_rst_n(rst1),
    .vga      (vif1)
  );

  vga_rom_pic_jump_top #(
    .H_SYNC(1), .H_BACK(1), .H_LEFT(1), .H_VALID(12), .H_RIGHT(1), .H_FRONT(1), .H_TOTAL(17),
    .V_SYNC(1), .V_BACK(1), .V_TOP(1), .V_VALID(8), .V_BOTTOM(1), .V_FRONT(1), .V_TOTAL(13),
    .H_PIC(4), .V_PIC(4), .PIC_SIZE(16)
  ) dut2 (
    .sys_clk  (sys_clk),
    .sys_rst_n(rst2),
    .vga      (vif2)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to a counter position measured in cycles since the last reset release.
  task automatic go(input int ft, input int ht, input int fr, input int v, input int h);
    int target;
    target = fr * ft + v * ht + h;
    if (target < cyc) begin
      total++;
      bad++;
      $error("FAIL go_order observed=%0d expected>=%0d", target, cyc);
    end else begin
      repeat (target - cyc) @(negedge sys_clk);
      cyc = target;
    end
  endtask

  initial begin
    int nz;
    int bf[8] = '{2, 4, 5, 8, 9, 12, 16, 17};
    int bx[8] = '{2, 4, 5, 8, 7, 4, 0, 1};
    int by[8] = '{2, 4, 3, 0, 1, 4, 0, 1};

    repeat (3) @(negedge sys_clk);
    chk("rst_hsync", 32'(vif1.hsync), 32'd1);
    chk("rst_vsync", 32'(vif1.vsync), 32'd1);
    chk("rst_rgb", 32'(vif1.vga_rgb), 32'h0);

    // Bounce path on the tiny instance: HS0=VS0=3, x in 0..8, y in 0..4.
    rst2 = 1'b0;
    cyc = 0;
    for (int i = 0; i < 8; i++) begin
      go(FT2, HT2, bf[i], 3 + by[i], 2 + bx[i]);
      chk($sformatf("bounce_left_f%0d", bf[i]), 32'(vif2.vga_rgb), 32'h0);
      go(FT2, HT2, bf[i], 3 + by[i], 3 + bx[i]);
      chk($sformatf("bounce_corner_f%0d", bf[i]), 32'(vif2.vga_rgb), 32'h8000);
      go(FT2, HT2, bf[i], 4 + by[i], 4 + bx[i]);
      chk($sformatf("bounce_diag_f%0d", bf[i]), 32'(vif2.vga_rgb), 32'h8005);
    end
    chk("dut1_still_in_rst", 32'(vif1.hsync), 32'd1);

    @(negedge sys_clk);
    rst1 = 1'b0;
    cyc = 0;
    go(FT1, HT1, 0, 0, 0);  chk("hs_h0", 32'(vif1.hsync), 32'd1);
    go(FT1, HT1, 0, 0, 1);  chk("hs_h1", 32'(vif1.hsync), 32'd1);
    go(FT1, HT1, 0, 0, 2);  chk("hs_h2", 32'(vif1.hsync), 32'd0);
    go(FT1, HT1, 0, 0, 69); chk("hs_h69", 32'(vif1.hsync), 32'd0);
    go(FT1, HT1, 0, 1, 0);  chk("hs_l1_h0", 32'(vif1.hsync), 32'd1);
    go(FT1, HT1, 0, 1, 1);  chk("hs_l1_h1", 32'(vif1.hsync), 32'd1);
    go(FT1, HT1, 0, 1, 2);  chk("hs_l1_h2", 32'(vif1.hsync), 32'd0);
    go(FT1, HT1, 0, 1, 69); chk("vs_l1", 32'(vif1.vsync), 32'd1);
    go(FT1, HT1, 0, 2, 0);  chk("vs_l2", 32'(vif1.vsync), 32'd0);

    go(FT1, HT1, 0, 6, 5);   chk("f0_v6_h5", 32'(vif1.vga_rgb), 32'h0);
    go(FT1, HT1, 0, 6, 6);   chk("f0_v6_h6", 32'(vif1.vga_rgb), 32'h8000);
    go(FT1, HT1, 0, 6, 15);  chk("f0_v6_h15", 32'(vif1.vga_rgb), 32'h8009);
    go(FT1, HT1, 0, 6, 16);  chk("f0_v6_h16", 32'(vif1.vga_rgb), 32'h0);
    go(FT1, HT1, 0, 7, 6);   chk("f0_v7_h6", 32'(vif1.vga_rgb), 32'h800A);
    go(FT1, HT1, 0, 15, 15); chk("f0_v15_h15", 32'(vif1.vga_rgb), 32'h8063);
    nz = 0;
    for (int h = 0; h < HT1; h++) begin
      go(FT1, HT1, 0, 16, h);
      if (vif1.vga_rgb !== 16'h0) nz++;
    end
    chk("f0_line16_black", 32'(nz), 32'd0);

    nz = 0;
    for (int h = 0; h < HT1; h++) begin
      go(FT1, HT1, 1, 6, h);
      if (vif1.vga_rgb !== 16'h0) nz++;
    end
    chk("f1_line6_black", 32'(nz), 32'd0);
    go(FT1, HT1, 1, 7, 6); chk("f1_v7_h6", 32'(vif1.vga_rgb), 32'h0);
    go(FT1, HT1, 1, 7, 7); chk("f1_v7_h7", 32'(vif1.vga_rgb), 32'h8000);

    // Frame 3 has the picture at (3,3); (10,10) is picture pixel (1,1).
    go(FT1, HT1, 3, 10, 10);
    chk("f3_pre_rst_rgb", 32'(vif1.vga_rgb), 32'h800B);
    chk("f3_pre_rst_vsync", 32'(vif1.vsync), 32'd0);
    rst1 = 1'b1;
    #1;
    chk("midrst_hsync", 32'(vif1.hsync), 32'd1);
    chk("midrst_vsync", 32'(vif1.vsync), 32'd1);
    chk("midrst_rgb", 32'(vif1.vga_rgb), 32'h0);
    repeat (3) @(negedge sys_clk);
    rst1 = 1'b0;
    cyc = 0;
    go(FT1, HT1, 0, 6, 5); chk("post_rst_v6_h5", 32'(vif1.vga_rgb), 32'h0);
    go(FT1, HT1, 0, 6, 6); chk("post_rst_v6_h6", 32'(vif1.vga_rgb), 32'h8000);
    go(FT1, HT1, 0, 7, 7); chk("post_rst_v7_h7", 32'(vif1.vga_rgb), 32'h800B);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
